// File: rtl/warp_issue_if.sv
// Decode-to-issue handshake plus the per-thread issue bus toward the SIMD lanes.
interface warp_issue_if;
  // Decode side
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  dec_func5;
  logic [17:0] dec_imm;
  logic [3:0]  dec_rs1;
  logic [3:0]  dec_rs2;
  logic [3:0]  dec_rd;
  logic [11:0] dec_ctrl;
  // Lane side
  logic [3:0]  thread_num;
  logic [4:0]  func5;
  logic [17:0] imm;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [10:0] iss_ctrl;

  // Decode / lane consumer view
  modport master (
    output instr_valid, dec_func5, dec_imm, dec_rs1, dec_rs2, dec_rd, dec_ctrl,
    input  instr_ready, thread_num, func5, imm, rs1, rs2, rd, iss_ctrl
  );

  // Issue stage view
  modport slave (
    input  instr_valid, dec_func5, dec_imm, dec_rs1, dec_rs2, dec_rd, dec_ctrl,
    output instr_ready, thread_num, func5, imm, rs1, rs2, rd, iss_ctrl
  );
endinterface

// File: rtl/warp_issue.sv
// Warp issue stage: replays each accepted instruction once per thread (barrel
// interleave), spaces accepts by the write-back latency, and drains on halt.
// Optional feature macro: ISSUE_PERF_CNT_EN (issued / bubble performance counters).
module warp_issue #(
  parameter int unsigned NUM_THREADS  = 16,
  parameter int unsigned MIN_GAP      = 13,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  warp_issue_if.slave  bus,
  output logic         done,
  output logic [31:0]  perf_issued,
  output logic [31:0]  perf_bubble
);

  localparam int unsigned SPACING = (NUM_THREADS > MIN_GAP) ? NUM_THREADS : MIN_GAP;
  localparam int unsigned SLOT_W  = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [3:0]  THR_LAST = 4'(NUM_THREADS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic [3:0]          r_thr, w_thr_nxt;
  logic                r_busy, w_busy_nxt;
  logic [DRAIN_W-1:0]  r_drain, w_drain_nxt;
  logic                w_accept, w_emit;
  logic [3:0]          w_emit_thr;
  logic                w_ready_nxt, w_done_nxt;

  logic [4:0]  r_lat_func5;
  logic [17:0] r_lat_imm;
  logic [3:0]  r_lat_rs1, r_lat_rs2, r_lat_rd;
  logic [10:0] r_lat_ctrl;

  logic [4:0]  w_src_func5;
  logic [17:0] w_src_imm;
  logic [3:0]  w_src_rs1, w_src_rs2, w_src_rd;
  logic [10:0] w_src_ctrl;

  logic        r_ready, r_done;
  logic [3:0]  r_thread_num;
  logic [4:0]  r_func5;
  logic [17:0] r_imm;
  logic [3:0]  r_rs1, r_rs2, r_rd;
  logic [10:0] r_iss_ctrl;

  // Thread 0 issues in the accept cycle's successor, so it bypasses the latch
  assign w_src_func5 = w_accept ? bus.dec_func5       : r_lat_func5;
  assign w_src_imm   = w_accept ? bus.dec_imm         : r_lat_imm;
  assign w_src_rs1   = w_accept ? bus.dec_rs1         : r_lat_rs1;
  assign w_src_rs2   = w_accept ? bus.dec_rs2         : r_lat_rs2;
  assign w_src_rd    = w_accept ? bus.dec_rd          : r_lat_rd;
  assign w_src_ctrl  = w_accept ? bus.dec_ctrl[10:0]  : r_lat_ctrl;

  // FSM and replay counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_thr   <= '0;
      r_busy  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_thr   <= w_thr_nxt;
      r_busy  <= w_busy_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next state, accept decision and which thread (if any) issues next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_thr_nxt   = r_thr;
    w_busy_nxt  = r_busy;
    w_drain_nxt = r_drain;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_emit_thr  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_slot_nxt  = '0;
          w_thr_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        w_accept = bus.instr_valid & r_ready;
        if (r_slot != '0) w_slot_nxt = r_slot - SLOT_W'(1);
        if (r_busy) begin
          w_emit     = 1'b1;
          w_emit_thr = r_thr;
          if (r_thr == THR_LAST) begin
            w_busy_nxt = 1'b0;
            w_thr_nxt  = '0;
          end else begin
            w_thr_nxt  = r_thr + 4'd1;
          end
        end
        if (w_accept) begin
          if (bus.dec_ctrl[11]) begin
            w_busy_nxt  = 1'b0;
            w_drain_nxt = DRAIN_W'(DRAIN_CYCLES);
            w_state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          end else begin
            w_emit     = 1'b1;
            w_emit_thr = '0;
            w_slot_nxt = SLOT_W'(SPACING - 1);
            w_thr_nxt  = 4'd1;
            w_busy_nxt = (NUM_THREADS > 1);
          end
        end
      end
      S_DRAIN: begin
        if (r_drain <= DRAIN_W'(1)) w_state_nxt = S_DONE;
        else                        w_drain_nxt = r_drain - DRAIN_W'(1);
      end
      S_DONE: ;
      default: w_state_nxt = S_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == S_RUN) && (w_slot_nxt == '0);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  // Hold the accepted instruction for the rest of the replay
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_func5 <= '0;
      r_lat_imm   <= '0;
      r_lat_rs1   <= '0;
      r_lat_rs2   <= '0;
      r_lat_rd    <= '0;
      r_lat_ctrl  <= '0;
    end else if (w_accept) begin
      r_lat_func5 <= bus.dec_func5;
      r_lat_imm   <= bus.dec_imm;
      r_lat_rs1   <= bus.dec_rs1;
      r_lat_rs2   <= bus.dec_rs2;
      r_lat_rd    <= bus.dec_rd;
      r_lat_ctrl  <= bus.dec_ctrl[10:0];
    end
  end

  // Registered outputs; non-issue cycles are all-zero bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_thread_num <= '0;
      r_func5      <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_iss_ctrl   <= '0;
    end else begin
      r_ready      <= w_ready_nxt;
      r_done       <= w_done_nxt;
      r_thread_num <= w_emit ? w_emit_thr  : 4'd0;
      r_func5      <= w_emit ? w_src_func5 : 5'd0;
      r_imm        <= w_emit ? w_src_imm   : 18'd0;
      r_rs1        <= w_emit ? w_src_rs1   : 4'd0;
      r_rs2        <= w_emit ? w_src_rs2   : 4'd0;
      r_rd         <= w_emit ? w_src_rd    : 4'd0;
      r_iss_ctrl   <= w_emit ? w_src_ctrl  : 11'd0;
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.thread_num  = r_thread_num;
  assign bus.func5       = r_func5;
  assign bus.imm         = r_imm;
  assign bus.rs1         = r_rs1;
  assign bus.rs2         = r_rs2;
  assign bus.rd          = r_rd;
  assign bus.iss_ctrl    = r_iss_ctrl;
  assign done            = r_done;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] r_perf_issued, r_perf_bubble;

  // Saturating counts of issue slots and RUN-state bubbles, updated with the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_emit && (r_perf_issued != 32'hFFFF_FFFF))
        r_perf_issued <= r_perf_issued + 32'd1;
      if ((r_state == S_RUN) && !w_emit && (r_perf_bubble != 32'hFFFF_FFFF))
        r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_bubble = r_perf_bubble;
`else
  assign perf_issued = 32'd0;
  assign perf_bubble = 32'd0;
`endif

endmodule

// File: tb/tb_warp_issue.sv
// Directed bench for warp_issue: a small-config instance (4 threads, gap 6,
// drain 3) driven from a vector table, and a 16-thread instance for the
// back-to-back replay stream.
module tb_warp_issue;

  typedef struct packed {
    logic [4:0]  func5;
    logic [17:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [11:0] ctrl;
  } instr_t;

  typedef struct {
    logic st;     // start input
    logic v;      // instr_valid input
    int   in_sel; // instruction presented on dec_*
    logic er;     // expected instr_ready
    int   thr;    // expected thread_num
    int   esel;   // instruction expected on the lane bus (0 = bubble)
    logic ed;     // expected done
  } vec_t;

  logic clk;
  logic rst_a, start_a, done_a;
  logic rst_b, start_b, done_b;
  logic [31:0] perf_issued_a, perf_bubble_a, perf_issued_b, perf_bubble_b;

  int n_vec;
  int n_err;
  vec_t vq[$];

  warp_issue_if bus_a ();
  warp_issue_if bus_b ();

  warp_issue #(.NUM_THREADS(4), .MIN_GAP(6), .DRAIN_CYCLES(3)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .bus(bus_a),
    .done(done_a), .perf_issued(perf_issued_a), .perf_bubble(perf_bubble_a)
  );

  warp_issue #(.NUM_THREADS(16), .MIN_GAP(13), .DRAIN_CYCLES(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .bus(bus_b),
    .done(done_b), .perf_issued(perf_issued_b), .perf_bubble(perf_bubble_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 = int add, 2 = pred_getter+memwrite, 3 = junk, 4 = halt, 0 = nothing
  function automatic instr_t instr_of(input int sel);
    instr_t ins;
    case (sel)
      1:       ins = '{func5: 5'd3,  imm: 18'd7,       rs1: 4'd1,  rs2: 4'd2,  rd: 4'd5,  ctrl: 12'h001};
      2:       ins = '{func5: 5'd17, imm: 18'h2_0001,  rs1: 4'd3,  rs2: 4'd4,  rd: 4'd9,  ctrl: 12'h420};
      3:       ins = '{func5: 5'd31, imm: 18'h3_FFFF,  rs1: 4'd15, rs2: 4'd15, rd: 4'd15, ctrl: 12'h00F};
      4:       ins = '{func5: 5'd0,  imm: 18'd0,       rs1: 4'd0,  rs2: 4'd0,  rd: 4'd0,  ctrl: 12'h800};
      5:       ins = '{func5: 5'd9,  imm: 18'h2_ABCD,  rs1: 4'd6,  rs2: 4'd7,  rd: 4'd12, ctrl: 12'h001};
      default: ins = '0;
    endcase
    return ins;
  endfunction

  function automatic logic [63:0] exp_of(input logic rdy, input int thr, input int sel, input logic dn);
    instr_t ins;
    ins = instr_of(sel);
    return 64'({rdy, 4'(thr), ins.func5, ins.imm, ins.rs1, ins.rs2, ins.rd, ins.ctrl[10:0], dn});
  endfunction

  function automatic logic [63:0] act_a();
    return 64'({bus_a.instr_ready, bus_a.thread_num, bus_a.func5, bus_a.imm, bus_a.rs1,
                bus_a.rs2, bus_a.rd, bus_a.iss_ctrl, done_a});
  endfunction

  function automatic logic [63:0] act_b();
    return 64'({bus_b.instr_ready, bus_b.thread_num, bus_b.func5, bus_b.imm, bus_b.rs1,
                bus_b.rs2, bus_b.rd, bus_b.iss_ctrl, done_b});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic v, input int sel);
    instr_t ins;
    ins = instr_of(sel);
    bus_a.instr_valid = v;
    bus_a.dec_func5   = ins.func5;
    bus_a.dec_imm     = ins.imm;
    bus_a.dec_rs1     = ins.rs1;
    bus_a.dec_rs2     = ins.rs2;
    bus_a.dec_rd      = ins.rd;
    bus_a.dec_ctrl    = ins.ctrl;
  endtask

  task automatic drive_b(input logic v, input int sel);
    instr_t ins;
    ins = instr_of(sel);
    bus_b.instr_valid = v;
    bus_b.dec_func5   = ins.func5;
    bus_b.dec_imm     = ins.imm;
    bus_b.dec_rs1     = ins.rs1;
    bus_b.dec_rs2     = ins.rs2;
    bus_b.dec_rd      = ins.rd;
    bus_b.dec_ctrl    = ins.ctrl;
  endtask

  task automatic add(input logic st, input logic v, input int in_sel,
                     input logic er, input int thr, input int esel, input logic ed);
    vec_t t;
    t = '{st: st, v: v, in_sel: in_sel, er: er, thr: thr, esel: esel, ed: ed};
    vq.push_back(t);
  endtask

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;

    // Vector table: inputs for cycle i and the outputs expected in cycle i
    add(1, 0, 0, 0, 0, 0, 0); // 0  reset state; start
    add(0, 1, 1, 1, 0, 0, 0); // 1  ready, add accepted (c=1)
    add(0, 1, 1, 0, 0, 1, 0); // 2  thread 0
    add(0, 1, 1, 0, 1, 1, 0); // 3  thread 1
    add(0, 1, 1, 0, 2, 1, 0); // 4  thread 2
    add(0, 1, 1, 0, 3, 1, 0); // 5  thread 3
    add(0, 0, 0, 0, 0, 0, 0); // 6  bubble
    add(0, 0, 0, 1, 0, 0, 0); // 7  ready again at c+6, valid held low
    add(0, 0, 0, 1, 0, 0, 0); // 8
    add(0, 0, 0, 1, 0, 0, 0); // 9
    add(0, 0, 0, 1, 0, 0, 0); // 10
    add(0, 0, 0, 1, 0, 0, 0); // 11
    add(0, 1, 2, 1, 0, 0, 0); // 12 pred_getter+memwrite accepted
    add(0, 1, 3, 0, 0, 2, 0); // 13 decode changes mid-replay
    add(0, 0, 3, 0, 1, 2, 0); // 14
    add(0, 0, 3, 0, 2, 2, 0); // 15
    add(0, 0, 3, 0, 3, 2, 0); // 16
    add(0, 0, 0, 0, 0, 0, 0); // 17
    add(0, 1, 4, 1, 0, 0, 0); // 18 halt accepted (c=18)
    add(0, 0, 0, 0, 0, 0, 0); // 19 drain
    add(0, 0, 0, 0, 0, 0, 0); // 20
    add(0, 0, 0, 0, 0, 0, 0); // 21 c+3, not yet done
    add(0, 0, 0, 0, 0, 0, 1); // 22 done from c+4
    add(1, 1, 1, 0, 0, 0, 1); // 23 start and valid ignored in DONE
    add(0, 0, 0, 0, 0, 0, 1); // 24
    add(0, 0, 0, 0, 0, 0, 1); // 25

    rst_a = 1'b1; start_a = 1'b0; drive_a(1'b0, 0);
    rst_b = 1'b1; start_b = 1'b0; drive_b(1'b0, 0);
    tick();
    tick();
    rst_a = 1'b0;

    foreach (vq[i]) begin
      chk($sformatf("vec%0d", i), act_a(), exp_of(vq[i].er, vq[i].thr, vq[i].esel, vq[i].ed));
      if (i == 16) begin
`ifdef ISSUE_PERF_CNT_EN
        chk("perf_two_instr", 64'({perf_issued_a, perf_bubble_a}), {32'd8, 32'd7});
`else
        chk("perf_tied_off", 64'({perf_issued_a, perf_bubble_a}), 64'd0);
`endif
      end
      start_a = vq[i].st;
      drive_a(vq[i].v, vq[i].in_sel);
      tick();
    end

    // Reset in the middle of a replay, then restart
    rst_a = 1'b1; start_a = 1'b0; drive_a(1'b0, 0);
    tick();
    rst_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rmr_first_ready", 64'(bus_a.instr_ready), 64'd1);
    drive_a(1'b1, 1);
    tick();
    drive_a(1'b0, 0);
    chk("rmr_thread0", act_a(), exp_of(1'b0, 0, 1, 1'b0));
    tick();
    tick();
    chk("rmr_thread2", act_a(), exp_of(1'b0, 2, 1, 1'b0));
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("rmr_after_rst", act_a(), exp_of(1'b0, 0, 0, 1'b0));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rmr_restart_ready", 64'(bus_a.instr_ready), 64'd1);
    drive_a(1'b1, 2);
    tick();
    drive_a(1'b0, 0);
    chk("rmr_restart_issue", act_a(), exp_of(1'b0, 0, 2, 1'b0));

    // 16 threads with gap 13: spacing equals the thread count, so no bubbles
    rst_b = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_first_ready", 64'(bus_b.instr_ready), 64'd1);
    drive_b(1'b1, 5);
    tick();
    for (int k = 0; k < 48; k++) begin
      chk($sformatf("b_stream%0d", k), act_b(), exp_of((k % 16) == 15, k % 16, 5, 1'b0));
      if (k == 47) begin
`ifdef ISSUE_PERF_CNT_EN
        chk("b_perf", 64'({perf_issued_b, perf_bubble_b}), {32'd48, 32'd0});
`else
        chk("b_perf_tied_off", 64'({perf_issued_b, perf_bubble_b}), 64'd0);
`endif
      end
      tick();
    end
    drive_b(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
